// File: rtl/bitcnt_pkg.sv
// Shared types and helpers for the pipelined bit-count unit (CLZ / CTZ / CPOP).
package bitcnt_pkg;

  typedef enum logic [1:0] {
    FUNC_CLZ  = 2'd0,
    FUNC_CTZ  = 2'd1,
    FUNC_CPOP = 2'd2,
    FUNC_RSVD = 2'd3
  } func_e;

  // din_func[HALF_BIT] selects the low half of the operand.
  localparam int HALF_BIT  = 0;
  localparam int REF_MAX_W = 256;

  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // Behavioural reference: count over the low w (or w/2) bits of x.
  function automatic int bitcnt_ref(input logic [REF_MAX_W-1:0] x, input int w,
                                    input logic [2:0] func);
    int   n;
    int   cnt;
    logic hit;
    n   = func[HALF_BIT] ? w / 2 : w;
    cnt = 0;
    hit = 1'b0;
    case (func_e'(func[2:1]))
      FUNC_CPOP: begin
        for (int i = 0; i < REF_MAX_W; i++)
          if (i < n && x[i]) cnt++;
      end
      FUNC_CTZ: begin
        for (int i = 0; i < REF_MAX_W; i++) begin
          if (i < n && !hit) begin
            if (x[i]) hit = 1'b1;
            else      cnt++;
          end
        end
      end
      FUNC_CLZ: begin
        for (int i = REF_MAX_W - 1; i >= 0; i--) begin
          if (i < n && !hit) begin
            if (x[i]) hit = 1'b1;
            else      cnt++;
          end
        end
      end
      default: cnt = 0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/bitcnt_popcnt_pipe.sv
// Popcount adder tree of WIDTH inputs, cut into STAGES register stages with
// per-stage valid bits and externally supplied load enables.
module bitcnt_popcnt_pipe
  import bitcnt_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [STAGES-1:0]      ld,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_vec,
  output logic [STAGES-1:0]      valid,
  output logic [$clog2(WIDTH):0] cnt
);

  localparam int CW   = cnt_width(WIDTH);
  localparam int LVLS = $clog2(WIDTH);

  // Level l of the tree holds WIDTH>>l partial sums; unused upper slots stay zero.
  typedef logic [WIDTH-1:0][CW-1:0] sums_t;

  function automatic sums_t widen(input logic [WIDTH-1:0] v);
    sums_t r;
    for (int i = 0; i < WIDTH; i++) r[i] = {{(CW-1){1'b0}}, v[i]};
    return r;
  endfunction

  function automatic sums_t reduce(input sums_t a, input int from_lvl, input int to_lvl);
    sums_t r;
    sums_t n;
    r = a;
    for (int l = 0; l < LVLS; l++) begin
      if (l >= from_lvl && l < to_lvl) begin
        n = '0;
        for (int i = 0; i < WIDTH / 2; i++)
          if (i < (WIDTH >> (l + 1))) n[i] = r[2*i] + r[2*i+1];
        r = n;
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] total(input sums_t a, input int from_lvl);
    sums_t r;
    r = reduce(a, from_lvl, LVLS);
    return r[0];
  endfunction

  logic [STAGES-1:0] valid_d, valid_q;
  logic [STAGES-1:0] take;

  // A stage captures new data only when it loads and its upstream holds a valid op.
  always_comb begin
    valid_d[0] = ld[0] ? in_valid : valid_q[0];
    take[0]    = ld[0] & in_valid;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = ld[k] ? valid_q[k-1] : valid_q[k];
      take[k]    = ld[k] & valid_q[k-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  assign valid = valid_q;

  sums_t link [STAGES];
  assign link[0] = widen(in_vec);

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int LO = ((k - 1) * LVLS) / STAGES;
    if (k < STAGES) begin : g_mid
      localparam int HI = (k * LVLS) / STAGES;
      sums_t sums_d, sums_q;

      always_comb begin
        sums_d = sums_q;
        if (take[k-1]) sums_d = reduce(link[k-1], LO, HI);
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) sums_q <= '0;
        else         sums_q <= sums_d;
      end

      assign link[k] = sums_q;
    end else begin : g_last
      logic [CW-1:0] cnt_d, cnt_q;

      always_comb begin
        cnt_d = cnt_q;
        if (take[k-1]) cnt_d = total(link[k-1], LO);
      end

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end

      assign cnt = cnt_q;
    end
  end

endmodule

// File: rtl/bitcnt_pipe.sv
// Pipelined CLZ/CTZ/CPOP unit: operand normalisation turns every function into
// a popcount, which the registered adder tree then evaluates.
module bitcnt_pipe
  import bitcnt_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din_data,
  input  logic [2:0]       din_func,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [WIDTH-1:0] dout_data
);

  localparam int H  = WIDTH / 2;
  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] LO_MASK = {{H{1'b0}}, {H{1'b1}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  func_e            op;
  logic             half;
  logic [WIDTH-1:0] nmask;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] rev;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] vec;

  // CTZ is popcount(~x & (x-1)) restricted to the active N bits; CLZ reuses it
  // on the N-bit reversal, which for half mode lands in the upper half first.
  always_comb begin
    op    = func_e'(din_func[2:1]);
    half  = din_func[HALF_BIT];
    nmask = half ? LO_MASK : '1;
    x     = din_data & nmask;
    for (int i = 0; i < WIDTH; i++) rev[i] = x[WIDTH-1-i];
    if (half) rev = rev >> H;
    sel = (op == FUNC_CLZ) ? rev : x;
    case (op)
      FUNC_CPOP:          vec = x;
      FUNC_CLZ, FUNC_CTZ: vec = ~sel & (sel - ONE) & nmask;
      default:            vec = '0;
    endcase
  end

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // Stage k loads when it, or any stage downstream of it, is empty, or when
  // the consumer takes the result; ready never looks at din_valid.
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] valid;
  logic [CW-1:0]     cnt;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ld[k] = dout_ready;
      for (int j = k; j < STAGES; j++)
        if (!valid[j]) ld[k] = 1'b1;
    end
  end

  bitcnt_popcnt_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_popcnt (
    .clock    (clock),
    .resetn   (resetn),
    .ld       (ld),
    .in_valid (din_valid),
    .in_vec   (vec),
    .valid    (valid),
    .cnt      (cnt)
  );

  assign din_ready  = ld[0];
  assign dout_valid = valid[STAGES-1];
  assign dout_data  = {{(WIDTH-CW){1'b0}}, cnt};

endmodule

// File: tb/tb_bitcnt_pipe.sv
// Directed bench for bitcnt_pipe (WIDTH=64, STAGES=2): latency, functions,
// half mode, reserved op, backpressure ordering and mid-stream reset.
module tb_bitcnt_pipe;

  logic        clock      = 1'b0;
  logic        resetn     = 1'b1;
  logic        din_valid  = 1'b0;
  logic        din_ready;
  logic [63:0] din_data   = '0;
  logic [2:0]  din_func   = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic [63:0] dout_data;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  bitcnt_pipe #(
    .WIDTH  (64),
    .STAGES (2)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_data   (din_data),
    .din_func   (din_func),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_data  (dout_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One op through an idle pipeline with dout_ready=1: result exactly 2 cycles later.
  task automatic run_op(input string tag, input logic [63:0] data, input logic [2:0] func,
                        input logic [63:0] exp);
    din_valid = 1'b1;
    din_data  = data;
    din_func  = func;
    #1;
    check({tag, " ready"}, din_ready, 1);
    tick();
    din_valid = 1'b0;
    check({tag, " early"}, dout_valid, 0);
    tick();
    check({tag, " valid"}, dout_valid, 1);
    check({tag, " data"}, dout_data, exp);
    tick();
  endtask

  logic [63:0] bp_data [4];
  logic [2:0]  bp_func [4];
  int          in_i;
  logic        accepted;

  initial begin
    // Reset
    #1 resetn = 1'b0;
    #11;
    check("reset dout_valid", dout_valid, 0);
    check("reset dout_data", dout_data, 0);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    check("reset din_ready", din_ready, 1);

    // Functions, full and half width
    run_op("cpop full",       64'hFFFF_0000_0000_00F1, 3'b100, 21);
    run_op("clz half",        64'hDEAD_BEEF_0000_8000, 3'b001, 16);
    run_op("ctz zero full",   64'h0,                   3'b010, 64);
    run_op("ctz zero half",   64'h0,                   3'b011, 32);
    run_op("clz one full",    64'h1,                   3'b000, 63);
    run_op("clz zero full",   64'h0,                   3'b000, 64);
    run_op("clz zero half",   64'h0,                   3'b001, 32);
    run_op("clz bit32 full",  64'h0000_0001_0000_0000, 3'b000, 31);
    run_op("clz ones half",   64'h0000_0000_FFFF_FFFF, 3'b001, 0);
    run_op("ctz msb full",    64'h8000_0000_0000_0000, 3'b010, 63);
    run_op("ctz upper half",  64'hFFFF_FFFF_0000_0000, 3'b011, 32);
    run_op("cpop half",       64'hFFFF_FFFF_0000_0003, 3'b101, 2);
    run_op("cpop ones full",  64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 64);
    run_op("reserved",        64'hFFFF_FFFF_FFFF_FFFF, 3'b110, 0);

    // Backpressure: output stalled for 5 cycles while 4 ops are offered
    bp_data[0] = 64'hF;                  bp_func[0] = 3'b100; exp_q.push_back(4);
    bp_data[1] = 64'h100;                bp_func[1] = 3'b010; exp_q.push_back(8);
    bp_data[2] = 64'h1;                  bp_func[2] = 3'b000; exp_q.push_back(63);
    bp_data[3] = 64'hFFFF_FFFF_FFFF_FFFF; bp_func[3] = 3'b101; exp_q.push_back(32);
    in_i = 0;
    for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
      dout_ready = (cyc >= 5);
      din_valid  = (in_i < 4);
      if (in_i < 4) begin
        din_data = bp_data[in_i];
        din_func = bp_func[in_i];
      end
      #1;
      if (cyc == 2) begin
        check("bp din_ready low", din_ready, 0);
        check("bp accepts before stall", in_i, 2);
      end
      if (cyc >= 2 && cyc < 5) begin
        check("bp hold valid", dout_valid, 1);
        check("bp hold data", dout_data, 4);
      end
      if (dout_valid && dout_ready) begin
        check("bp order", dout_data, exp_q[0]);
        void'(exp_q.pop_front());
      end
      accepted = din_valid && din_ready;
      @(posedge clock);
      #1;
      if (accepted) in_i++;
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    check("bp drained", exp_q.size(), 0);
    check("bp all accepted", in_i, 4);
    tick();
    check("bp idle after drain", dout_valid, 0);

    // Mid-stream reset with two ops in flight
    dout_ready = 1'b0;
    din_valid  = 1'b1;
    din_data   = 64'hFF;
    din_func   = 3'b100;
    tick();
    din_data   = 64'h3;
    tick();
    din_valid  = 1'b0;
    check("pre-reset valid", dout_valid, 1);
    check("pre-reset data", dout_data, 8);
    resetn = 1'b0;
    #1;
    check("mid reset dout_valid", dout_valid, 0);
    check("mid reset dout_data", dout_data, 0);
    #2;
    resetn     = 1'b1;
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post reset no emit", dout_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
